// File: rtl/pcie_lane_rx_aligner.sv
// rtl/pcie_lane_rx_aligner.sv - per-lane K28.5 comma hunt and 10b symbol boundary aligner
module pcie_lane_rx_aligner #(
  parameter int LOCK_COMMAS = 3,
  parameter int LOSS_COMMAS = 4
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Stable,
  input  logic       DataIn,
  output logic [9:0] SymbolOut,
  output logic       SymbolValid,
  output logic       SymbolIsComma,
  output logic       Locked,
  output logic       CommaErr
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [3:0] LockN = 4'(LOCK_COMMAS);
  localparam logic [3:0] LossN = 4'(LOSS_COMMAS);

  state_t     state, state_d;
  logic [9:0] window;
  logic [3:0] phase_cnt, phase_d;
  logic [3:0] comma_cnt, comma_d, comma_inc;
  logic [3:0] mis_cnt, mis_d, mis_inc;
  logic [9:0] sym_d;
  logic       valid_d, is_comma_d, err_d;
  logic       comma_match, boundary;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      window <= 10'h000;
    end else begin
      window <= {window[8:0], DataIn};
    end
  end

  always_comb begin
    comma_match = (window == 10'h0FA) || (window == 10'h305);
    boundary    = (phase_cnt == 4'd9);
    comma_inc   = (comma_cnt == 4'hF) ? comma_cnt : comma_cnt + 4'd1;
    mis_inc     = (mis_cnt == 4'hF) ? mis_cnt : mis_cnt + 4'd1;

    state_d    = state;
    phase_d    = boundary ? 4'd0 : phase_cnt + 4'd1;
    comma_d    = comma_cnt;
    mis_d      = mis_cnt;
    sym_d      = SymbolOut;
    valid_d    = 1'b0;
    is_comma_d = 1'b0;
    err_d      = 1'b0;

    // Losing link stability outranks every comma event in the same cycle.
    if (!Stable) begin
      state_d = HUNT;
      phase_d = 4'd0;
      comma_d = 4'd0;
      mis_d   = 4'd0;
    end else begin
      case (state)
        HUNT: begin
          if (comma_match) begin
            phase_d = 4'd0;
            comma_d = 4'd1;
            mis_d   = 4'd0;
            state_d = (LockN == 4'd1) ? LOCKED : CHECK;
          end
        end
        CHECK: begin
          if (comma_match) begin
            if (boundary) begin
              comma_d = comma_inc;
              if (comma_inc >= LockN) begin
                state_d = LOCKED;
                mis_d   = 4'd0;
              end
            end else begin
              err_d   = 1'b1;
              phase_d = 4'd0;
              comma_d = 4'd1;
            end
          end
        end
        LOCKED: begin
          if (boundary) begin
            sym_d      = window;
            valid_d    = 1'b1;
            is_comma_d = comma_match;
          end
          // Once locked, a stray comma never moves the boundary; only enough of them drop lock.
          if (comma_match) begin
            if (boundary) begin
              mis_d = 4'd0;
            end else begin
              err_d = 1'b1;
              mis_d = mis_inc;
              if (mis_inc >= LossN) begin
                state_d = HUNT;
                comma_d = 4'd0;
                mis_d   = 4'd0;
              end
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state         <= HUNT;
      phase_cnt     <= 4'd0;
      comma_cnt     <= 4'd0;
      mis_cnt       <= 4'd0;
      SymbolOut     <= 10'h000;
      SymbolValid   <= 1'b0;
      SymbolIsComma <= 1'b0;
      Locked        <= 1'b0;
      CommaErr      <= 1'b0;
    end else begin
      state         <= state_d;
      phase_cnt     <= phase_d;
      comma_cnt     <= comma_d;
      mis_cnt       <= mis_d;
      SymbolOut     <= sym_d;
      SymbolValid   <= valid_d;
      SymbolIsComma <= is_comma_d;
      Locked        <= (state_d == LOCKED);
      CommaErr      <= err_d;
    end
  end

endmodule

// File: tb/tb_pcie_lane_rx_aligner.sv
// tb/tb_pcie_lane_rx_aligner.sv - directed bench for pcie_lane_rx_aligner
module tb_pcie_lane_rx_aligner;

  logic       Clock;
  logic       Reset;
  logic       Stable;
  logic       DataIn;
  logic [9:0] SymbolOut;
  logic       SymbolValid;
  logic       SymbolIsComma;
  logic       Locked;
  logic       CommaErr;

  pcie_lane_rx_aligner #(.LOCK_COMMAS(3), .LOSS_COMMAS(4)) dut (
    .Clock(Clock), .Reset(Reset), .Stable(Stable), .DataIn(DataIn),
    .SymbolOut(SymbolOut), .SymbolValid(SymbolValid), .SymbolIsComma(SymbolIsComma),
    .Locked(Locked), .CommaErr(CommaErr)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [9:0] tbwin = 10'h000;
  logic [9:0] sv[$];
  logic       sc[$];
  int         st[$];
  int         ec[$];
  logic       elk[$];
  int lk_hi, stray, rise_cyc, fall_cyc;
  logic locked_prev = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    sv.delete(); sc.delete(); st.delete(); ec.delete(); elk.delete();
    lk_hi = 0; stray = 0; rise_cyc = -1; fall_cyc = -1;
  endtask

  task automatic tick(input logic b);
    DataIn = b;
    @(posedge Clock);
    #1;
    cyc++;
    tbwin = {tbwin[8:0], b};
    if (SymbolValid) begin
      sv.push_back(SymbolOut);
      sc.push_back(SymbolIsComma);
      st.push_back(cyc);
    end
    if (SymbolIsComma && !SymbolValid) stray++;
    if (CommaErr) begin
      ec.push_back(cyc);
      elk.push_back(Locked);
    end
    if (Locked) lk_hi++;
    if (Locked && !locked_prev) rise_cyc = cyc;
    if (!Locked && locked_prev) fall_cyc = cyc;
    locked_prev = Locked;
  endtask

  task automatic tick_nc(input logic b);
    logic bb;
    bb = b;
    if (({tbwin[8:0], bb} == 10'h0FA) || ({tbwin[8:0], bb} == 10'h305)) bb = ~bb;
    tick(bb);
  endtask

  task automatic send_sym(input logic [9:0] s);
    for (int i = 9; i >= 0; i--) tick(s[i]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  logic [9:0] exp_sym [10];
  logic       exp_cm  [10];
  logic [9:0] v;
  int c3, c_last, cs;

  initial begin
    Reset = 1'b0; Stable = 1'b0; DataIn = 1'b0;
    clear_log();

    // Test 1: reset holds everything at zero, even with a comma on the wire
    for (int i = 0; i < 12; i++) tick(i[0]);
    send_sym(10'h0FA);
    chk("t1_rst_symout", SymbolOut, 0);
    chk("t1_rst_valid_seen", sv.size(), 0);
    chk("t1_rst_iscomma", SymbolIsComma, 0);
    chk("t1_rst_locked_cycles", lk_hi, 0);
    chk("t1_rst_err_seen", ec.size(), 0);
    Reset = 1'b1; Stable = 1'b1; tbwin = 10'h000;
    clear_log();
    for (int i = 0; i < 200; i++) tick_nc(1'($urandom_range(0, 1)));
    chk("t1_rand_no_valid", sv.size(), 0);
    chk("t1_rand_no_lock", lk_hi, 0);
    chk("t1_rand_no_err", ec.size(), 0);

    // Test 2: three aligned commas lock, first strobe 10 cycles after lock
    for (int i = 0; i < 13; i++) tick_nc(1'b0);
    clear_log();
    send_sym(10'h0FA); send_sym(10'h305); send_sym(10'h0FA);
    c3 = cyc;
    chk("t2_unlocked_before_edge", Locked, 0);
    send_sym(10'h2AA);
    chk("t2_lock_edge", rise_cyc, c3 + 1);

    // Test 3: steady locked stream
    for (int k = 0; k < 3; k++) begin
      send_sym(10'h305); send_sym(10'h0FA); send_sym(10'h155);
    end
    send_sym(10'h155);
    exp_sym = '{10'h2AA, 10'h305, 10'h0FA, 10'h155, 10'h305, 10'h0FA, 10'h155, 10'h305, 10'h0FA, 10'h155};
    exp_cm  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    chk("t2_first_latency", (st.size() > 0) ? st[0] - rise_cyc : -1, 10);
    chk("t3_strobe_count", sv.size(), 10);
    for (int i = 0; i < 10 && i < sv.size(); i++) begin
      chk($sformatf("t3_sym%0d", i), sv[i], exp_sym[i]);
      chk($sformatf("t3_iscomma%0d", i), sc[i], exp_cm[i]);
      if (i > 0) chk($sformatf("t3_spacing%0d", i), st[i] - st[i-1], 10);
    end
    chk("t3_no_err", ec.size(), 0);
    chk("t3_no_stray_iscomma", stray, 0);

    // Test 4: one extra bit puts commas off boundary
    clear_log();
    tick(1'b0);
    for (int k = 0; k < 7; k++) send_sym(k[0] ? 10'h305 : 10'h0FA);
    c_last = cyc;
    send_sym(10'h155);
    chk("t4_err_count", ec.size(), 4);
    chk("t4_err_spacing", (ec.size() > 1) ? ec[1] - ec[0] : -1, 10);
    chk("t4_drop_on_4th", fall_cyc, (ec.size() > 3) ? ec[3] : -1);
    chk("t4_relock_edge", rise_cyc, c_last + 1);
    chk("t4_relock_gap", rise_cyc - fall_cyc, 30);
    chk("t4_locked_end", Locked, 1);

    // Test 6a: Stable low for one cycle at a strobe edge
    clear_log();
    send_sym(10'h155);
    v = 10'h2AA;
    Stable = 1'b0;
    tick(v[9]);
    Stable = 1'b1;
    chk("t6_stable_locked", Locked, 0);
    chk("t6_stable_valid", SymbolValid, 0);
    for (int i = 8; i >= 0; i--) tick(v[i]);
    send_sym(10'h0FA); send_sym(10'h305); send_sym(10'h155);
    chk("t6_two_commas_unlocked", Locked, 0);
    send_sym(10'h0FA);
    c_last = cyc;
    send_sym(10'h155);
    chk("t6_relock_edge", rise_cyc, c_last + 1);
    chk("t6_no_err", ec.size(), 0);

    // Test 6b: asynchronous reset mid-symbol
    tick(1'b1); tick(1'b0); tick(1'b1);
    chk("t6r_pre_symout", SymbolOut, 10'h155);
    chk("t6r_pre_locked", Locked, 1);
    #3 Reset = 1'b0;
    #1;
    chk("t6r_symout", SymbolOut, 0);
    chk("t6r_locked", Locked, 0);
    chk("t6r_valid", SymbolValid, 0);
    chk("t6r_err", CommaErr, 0);
    tick(1'b0); tick(1'b0);
    Reset = 1'b1;
    clear_log();
    send_sym(10'h0FA); send_sym(10'h305); send_sym(10'h155);
    chk("t6r_two_commas_unlocked", Locked, 0);
    send_sym(10'h0FA);
    c_last = cyc;
    send_sym(10'h155);
    chk("t6r_relock_edge", rise_cyc, c_last + 1);

    // Test 5: CHECK with a comma shifted by 5 bits
    clear_log();
    Stable = 1'b0;
    tick(1'b0);
    Stable = 1'b1;
    chk("t5_hunt_unlocked", Locked, 0);
    send_sym(10'h0FA); send_sym(10'h305);
    tick(1'b1); tick(1'b0); tick(1'b1); tick(1'b0); tick(1'b1);
    send_sym(10'h0FA);
    cs = cyc;
    send_sym(10'h305); send_sym(10'h0FA);
    c_last = cyc;
    send_sym(10'h155);
    chk("t5_err_count", ec.size(), 1);
    chk("t5_err_edge", (ec.size() > 0) ? ec[0] : -1, cs + 1);
    chk("t5_err_unlocked", (elk.size() > 0) ? elk[0] : 1'bx, 0);
    chk("t5_lock_edge", rise_cyc, c_last + 1);
    chk("t5_no_stray_iscomma", stray, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
